// File: rtl/v850_pkg.sv
// Shared types for the V850 decode stage: ALU ops, opcode map, decoded bundle.
package v850_pkg;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_MOV = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_CMP = 4'd7
  } alu_op_e;

  localparam logic [5:0] OP_MOV   = 6'b000000;
  localparam logic [5:0] OP_OR    = 6'b001000;
  localparam logic [5:0] OP_XOR   = 6'b001001;
  localparam logic [5:0] OP_AND   = 6'b001010;
  localparam logic [5:0] OP_SUB   = 6'b001101;
  localparam logic [5:0] OP_ADD   = 6'b001110;
  localparam logic [5:0] OP_CMP   = 6'b001111;
  localparam logic [5:0] OP_MOVI5 = 6'b010000;
  localparam logic [5:0] OP_ADDI5 = 6'b010010;
  localparam logic [5:0] OP_CMPI5 = 6'b010011;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ORI   = 6'b110100;
  localparam logic [5:0] OP_XORI  = 6'b110101;
  localparam logic [5:0] OP_ANDI  = 6'b110110;

  typedef struct packed {
    logic [1:0]  len;
    alu_op_e     alu_op;
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic [31:0] imm;
    logic        use_imm;
    logic        wb_en;
    logic        illegal;
  } decoded_t;

  function automatic logic [31:0] sext5(input logic [4:0] v);
    return {{27{v[4]}}, v};
  endfunction

endpackage

// File: rtl/inst_decode_comb.sv
// Pure combinational V850 field/immediate decode of the first two halfwords.
module inst_decode_comb
  import v850_pkg::*;
(
  input  logic [15:0] hw0,
  input  logic [15:0] hw1,
  output decoded_t    dec
);

  logic [5:0]  opc;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic        is32;
  logic        ok;
  logic        use_i;
  logic [31:0] imm;
  alu_op_e     op;

  assign r2   = hw0[15:11];
  assign opc  = hw0[10:5];
  assign r1   = hw0[4:0];
  assign is32 = (opc[5:4] == 2'b11) && (r2 != 5'd0);

  always_comb begin
    ok    = 1'b1;
    use_i = 1'b0;
    imm   = '0;
    op    = ALU_NOP;
    unique case (opc)
      OP_MOV: op = ALU_MOV;
      OP_OR:  op = ALU_OR;
      OP_XOR: op = ALU_XOR;
      OP_AND: op = ALU_AND;
      OP_SUB: op = ALU_SUB;
      OP_ADD: op = ALU_ADD;
      OP_CMP: op = ALU_CMP;
      OP_MOVI5: begin
        op = ALU_MOV; use_i = 1'b1; imm = sext5(r1);
      end
      OP_ADDI5: begin
        op = ALU_ADD; use_i = 1'b1; imm = sext5(r1);
      end
      OP_CMPI5: begin
        op = ALU_CMP; use_i = 1'b1; imm = sext5(r1);
      end
      OP_ADDI: begin
        op = ALU_ADD; use_i = 1'b1;
        imm = {{16{hw1[15]}}, hw1};
      end
      OP_ORI: begin
        op = ALU_OR; use_i = 1'b1; imm = {16'h0, hw1};
      end
      OP_XORI: begin
        op = ALU_XOR; use_i = 1'b1; imm = {16'h0, hw1};
      end
      OP_ANDI: begin
        op = ALU_AND; use_i = 1'b1; imm = {16'h0, hw1};
      end
      default: ok = 1'b0;
    endcase
    // 32-bit opcode space with reg2==0 is reserved
    if (opc[5:4] == 2'b11 && r2 == 5'd0)
      ok = 1'b0;
    if (hw0 == 16'h0000) begin
      ok = 1'b1;
      op = ALU_NOP;
    end
    if (!ok) begin
      op    = ALU_NOP;
      use_i = 1'b0;
      imm   = '0;
    end
    dec         = '0;
    dec.len     = {1'b0, is32};
    dec.alu_op  = op;
    dec.reg1    = r1;
    dec.reg2    = r2;
    dec.imm     = imm;
    dec.use_imm = use_i;
    dec.illegal = !ok;
    dec.wb_en   = ok && (op != ALU_NOP) && (op != ALU_CMP)
                  && (r2 != 5'd0);
  end

endmodule

// File: rtl/inst_decoder.sv
// V850 decode stage: handshake and registered decoded bundle.
// Optional skid entry enabled with DECODER_SKID_EN.
module inst_decoder
  import v850_pkg::*;
#(
  parameter int PC_W   = 25,
  parameter int INST_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [INST_W-1:0] instruction_i,
  input  logic [PC_W-1:0]   PC_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [PC_W-1:0]   PC_o,
  output logic [1:0]        len_o,
  output alu_op_e           alu_op_o,
  output logic [4:0]        reg1_o,
  output logic [4:0]        reg2_o,
  output logic [31:0]       imm_o,
  output logic              use_imm_o,
  output logic              wb_en_o,
  output logic              illegal_o
);

  decoded_t        dec;
  decoded_t        out_q;
  logic [PC_W-1:0] pc_q;
  logic            v_q;
  logic            accept;
  logic            retire;
  logic            unused_hi;

  assign unused_hi = ^instruction_i[INST_W-1:32];

  inst_decode_comb u_comb (
    .hw0 (instruction_i[15:0]),
    .hw1 (instruction_i[31:16]),
    .dec (dec)
  );

  assign accept = valid_i && ready_o;
  assign retire = v_q && ready_i;

`ifdef DECODER_SKID_EN
  decoded_t        skid_q;
  logic [PC_W-1:0] skid_pc;
  logic            skid_v;

  assign ready_o = !skid_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= 1'b0;
      out_q   <= '0;
      pc_q    <= '0;
      skid_v  <= 1'b0;
      skid_q  <= '0;
      skid_pc <= '0;
    end else if (flush_i) begin
      v_q    <= 1'b0;
      skid_v <= 1'b0;
    end else if (!v_q || retire) begin
      // skid full implies ready_o=0, so no accept races the drain
      if (skid_v) begin
        out_q  <= skid_q;
        pc_q   <= skid_pc;
        v_q    <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        v_q <= accept;
        if (accept) begin
          out_q <= dec;
          pc_q  <= PC_i;
        end
      end
    end else if (accept) begin
      skid_q  <= dec;
      skid_pc <= PC_i;
      skid_v  <= 1'b1;
    end
  end
`else
  assign ready_o = !v_q || ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      out_q <= '0;
      pc_q  <= '0;
    end else if (flush_i) begin
      v_q <= 1'b0;
    end else if (ready_o) begin
      v_q <= valid_i;
      if (valid_i) begin
        out_q <= dec;
        pc_q  <= PC_i;
      end
    end
  end
`endif

  assign valid_o   = v_q;
  assign PC_o      = pc_q;
  assign len_o     = out_q.len;
  assign alu_op_o  = out_q.alu_op;
  assign reg1_o    = out_q.reg1;
  assign reg2_o    = out_q.reg2;
  assign imm_o     = out_q.imm;
  assign use_imm_o = out_q.use_imm;
  assign wb_en_o   = out_q.wb_en;
  assign illegal_o = out_q.illegal;

endmodule
